// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg
// Shared types for the MIPS multiply/divide unit: operation encoding,
// FSM state encoding and a width-agnostic magnitude helper.
package mips_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // Widest operand md_abs can handle; callers zero-extend into it and
    // cast the result back to their own width.
    localparam int MD_MAX_W = 128;

    // Magnitude of a two's complement value. The sign is passed separately
    // because the helper cannot know where the caller's sign bit sits.
    // Negating the zero-extended value leaves the correct magnitude in the
    // caller's low bits, including most-negative -> 2**(W-1).
    function automatic logic [MD_MAX_W-1:0] md_abs(input logic [MD_MAX_W-1:0] v,
                                                   input logic                neg);
        return neg ? (~v + MD_MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/mips_muldiv_seq.sv
// mips_muldiv_seq
// Iterative one-bit-per-cycle engine: restoring division or shift-add
// multiply on unsigned magnitudes. Sign handling lives in the top.
//
// Ports
//   clk_i, rst_ni   clock, async active-low reset
//   load_i          start a new operation (counter <- WIDTH)
//   cancel_i        abort; counter cleared, engine goes quiet
//   is_div_i        1 = divide, 0 = multiply (sampled with load_i)
//   opa_i           dividend / multiplier magnitude
//   opb_i           divisor / multiplicand magnitude
//   last_o          high during the final iteration
//   acc_o           divide: {remainder, quotient}; multiply: product
module mips_muldiv_seq
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               cancel_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] acc_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH:0]     part_rem;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     sum;

    always_comb begin
        // Divide keeps {remainder, dividend/quotient} in acc; the shifted
        // partial remainder picks up the next dividend bit from acc[WIDTH-1].
        part_rem = acc_q[2*WIDTH-1:WIDTH-1];
        diff     = part_rem - {1'b0, opnd_q};
        // Multiply keeps {partial product, remaining multiplier bits} in acc.
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;

        if (cancel_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d    = CW'(WIDTH);
            is_div_d = is_div_i;
            opnd_d   = opb_i;
            acc_d    = {{WIDTH{1'b0}}, opa_i};
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (is_div_q) begin
                // diff[WIDTH] set means the trial subtract went negative: restore.
                if (diff[WIDTH]) begin
                    acc_d = {part_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end
            end else begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
        end
    end

    assign last_o = (cnt_q == CW'(1));
    assign acc_o  = acc_q;

endmodule

// File: rtl/mips_muldiv.sv
// mips_muldiv
// Multiply/divide unit with HI/LO result registers. Divides (and, in the
// default build, multiplies) run iteratively for WIDTH cycles plus one
// sign-fix cycle; MTHI/MTLO write in a single cycle.
//
// Build option
//   MULDIV_FAST_MUL_EN  defined: MULT/MULTU use a combinational multiplier
//                       registered straight into HI/LO (1-cycle, busy stays 0).
//                       undefined: MULT/MULTU go through the iterative engine.
//
// Ports
//   clk_i      rising-edge clock
//   rst_ni     async active-low reset
//   start_i    request strobe, sampled only while busy_o = 0
//   op_i       md_op_t operation; codes 6/7 are ignored
//   a_i, b_i   rs / rt operands
//   cancel_i   flush: abort in-flight op, drop a simultaneous start
//   busy_o     operation in progress
//   done_o     one-cycle pulse after HI/LO were updated
//   hi_o, lo_o HI / LO registers
//
// state | meaning
// IDLE  | waiting for a request; single-cycle ops complete here
// CALC  | engine iterating, one bit per cycle
// FIX   | sign correction, HI/LO written on exit
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  md_op_t           op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    md_state_t          state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               dz_q, dz_d;
    logic               div_q, div_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;

    logic               op_signed;
    logic               op_is_div;
    logic               seq_load;
    logic               seq_last;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] seq_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign op_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
    assign op_is_div = (op_i == MD_DIV) || (op_i == MD_DIVU);

    assign a_mag = WIDTH'(md_abs(MD_MAX_W'(a_i), op_signed & a_i[WIDTH-1]));
    assign b_mag = WIDTH'(md_abs(MD_MAX_W'(b_i), op_signed & b_i[WIDTH-1]));

    // Most-negative / -1 yields magnitude 2**(WIDTH-1); negating it gives the
    // same bit pattern, so the overflow case needs no special handling.
    assign prod_fix = neg_q     ? -seq_acc                  : seq_acc;
    assign quo_fix  = neg_q     ? -seq_acc[WIDTH-1:0]       : seq_acc[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? -seq_acc[2*WIDTH-1:WIDTH] : seq_acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_a;
    logic [2*WIDTH-1:0] fast_b;
    logic [2*WIDTH-1:0] fast_prod;

    // Extending to 2*WIDTH first lets one multiplier serve both signednesses.
    assign fast_a    = (op_i == MD_MULT) ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
    assign fast_b    = (op_i == MD_MULT) ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
    assign fast_prod = fast_a * fast_b;
`endif

    mips_muldiv_seq #(
        .WIDTH (WIDTH)
    ) u_seq (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (seq_load),
        .cancel_i (cancel_i),
        .is_div_i (op_is_div),
        .opa_i    (a_mag),
        .opb_i    (b_mag),
        .last_o   (seq_last),
        .acc_o    (seq_acc)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        div_d     = div_q;
        dvd_d     = dvd_q;
        seq_load  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !cancel_i) begin
                    case (op_i)
                        MD_DIV, MD_DIVU: begin
                            seq_load = 1'b1;
                            div_d    = 1'b1;
                            state_d  = CALC;
                        end
                        MD_MULT, MD_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                            hi_d   = fast_prod[2*WIDTH-1:WIDTH];
                            lo_d   = fast_prod[WIDTH-1:0];
                            done_d = 1'b1;
`else
                            seq_load = 1'b1;
                            div_d    = 1'b0;
                            state_d  = CALC;
`endif
                        end
                        MD_MTHI: begin
                            hi_d   = a_i;
                            done_d = 1'b1;
                        end
                        MD_MTLO: begin
                            lo_d   = a_i;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                    if (seq_load) begin
                        neg_d     = op_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        rem_neg_d = op_signed & a_i[WIDTH-1];
                        dz_d      = (b_i == '0);
                        dvd_d     = a_i;
                    end
                end
            end
            CALC: begin
                if (cancel_i) begin
                    state_d = IDLE;
                end else if (seq_last) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!cancel_i) begin
                    done_d = 1'b1;
                    if (!div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (dz_q) begin
                        // Divide by zero reports the raw dividend, not its magnitude.
                        hi_d = dvd_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            div_q     <= 1'b0;
            dvd_q     <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            div_q     <= div_d;
            dvd_q     <= dvd_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
